// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default geometry, the clog2 helper and the
// index-to-one-hot decode used by the write enables and by the read-side muxing.
package regfile_pkg;

  localparam int unsigned DefaultWidth    = 32;
  localparam int unsigned DefaultAddrBits = 5;
  localparam int unsigned DefaultNreq     = 4;

  // Widest register index the decode helper supports.
  localparam int unsigned MaxAddrBits = 8;
  localparam int unsigned MaxEntries  = 1 << MaxAddrBits;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [MaxEntries-1:0] idx_to_onehot(input logic [MaxAddrBits-1:0] idx);
    logic [MaxEntries-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching from ptr
// upwards, wrapping modulo N.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [clog2(N)-1:0] ptr,
  output logic                gnt_valid,
  output logic [clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IdxW = clog2(N);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ requesters, each with a
// one-entry holding buffer, drained one per cycle in round-robin order.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned ADDR_BITS = DefaultAddrBits,
  parameter int unsigned NREQ      = DefaultNreq
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ADDR_BITS-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic                      wr_valid,
  output logic [ADDR_BITS-1:0]      wr_addr,
  output logic [WIDTH-1:0]          wr_data,
  output logic [2**ADDR_BITS-1:0]   wr_enables,
  output logic [clog2(NREQ)-1:0]    grant_id
);

  localparam int unsigned IdW      = clog2(NREQ);
  localparam int unsigned NEntries = 1 << ADDR_BITS;

  logic [NREQ-1:0]      full_q, full_d, accept;
  logic [ADDR_BITS-1:0] buf_addr_q [NREQ];
  logic [WIDTH-1:0]     buf_data_q [NREQ];
  logic [IdW-1:0]       ptr_q, ptr_d;

  logic                 wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]     wr_data_q, wr_data_d;
  logic [IdW-1:0]       grant_id_q, grant_id_d;

  logic                 gnt_valid;
  logic [IdW-1:0]       gnt_idx;

  rr_pick #(
    .N(NREQ)
  ) u_pick (
    .req      (full_q),
    .ptr      (ptr_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  assign req_ready = ~full_q;
  assign accept    = req_valid & ~full_q;

  // A granted buffer is full and an accepting one is empty, so both can apply on one edge.
  always_comb begin
    full_d     = full_q | accept;
    ptr_d      = ptr_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    grant_id_d = grant_id_q;
    if (gnt_valid) begin
      full_d[gnt_idx] = 1'b0;
      wr_valid_d      = 1'b1;
      wr_addr_d       = buf_addr_q[gnt_idx];
      wr_data_d       = buf_data_q[gnt_idx];
      grant_id_d      = gnt_idx;
      if (int'(gnt_idx) == int'(NREQ) - 1) ptr_d = '0;
      else                                 ptr_d = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= '0;
      ptr_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      full_q     <= full_d;
      ptr_q      <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Payload storage needs no reset; validity lives in full_q.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        buf_addr_q[i] <= req_addr[i*ADDR_BITS +: ADDR_BITS];
        buf_data_q[i] <= req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  logic [MaxEntries-1:0] addr_dec;

  always_comb begin
    addr_dec   = idx_to_onehot(MaxAddrBits'(wr_addr_q));
    wr_enables = '0;
    if (wr_valid_q) wr_enables = addr_dec[NEntries-1:0];
    // r0 is hardwired to zero.
    wr_enables[0] = 1'b0;
  end

  if (NEntries < MaxEntries) begin : g_dec_sink
    logic unused_dec_hi;
    assign unused_dec_hi = ^addr_dec[MaxEntries-1:NEntries];
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the driver runs a behavioural model and queues expected
// grants/ready vectors; a monitor compares them against the DUT every cycle.
module tb_regfile_write_arbiter;

  localparam int W  = 32;
  localparam int AB = 5;
  localparam int N  = 4;
  localparam int NE = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AB-1:0] req_addr = '0;
  logic [N*W-1:0]  req_data = '0;
  logic            wr_valid;
  logic [AB-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic [NE-1:0]   wr_enables;
  logic [1:0]      grant_id;

  regfile_write_arbiter #(
    .WIDTH    (W),
    .ADDR_BITS(AB),
    .NREQ     (N)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_enables(wr_enables),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached register bank: no reset, captures on any enabled bit.
  logic [W-1:0] bank [NE] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < NE; i++) if (wr_enables[i]) bank[i] <= wr_data;
  end

  typedef struct {
    int            edge_n;
    logic [AB-1:0] addr;
    logic [W-1:0]  data;
    int            gid;
  } grant_t;

  typedef struct {
    int           edge_n;
    logic [N-1:0] ready;
  } rdy_t;

  grant_t gq[$];
  rdy_t   rq[$];

  // Reference model state.
  bit            m_full [N];
  logic [AB-1:0] m_addr [N];
  logic [W-1:0]  m_data [N];
  int            m_ptr = 0;
  logic [W-1:0]  exp_bank [NE] = '{default: '0};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then wait it out.
  task automatic step(input bit rst, input logic [N-1:0] v, input logic [N*AB-1:0] a,
                      input logic [N*W-1:0] d);
    bit [N-1:0]   was_full;
    int           g;
    grant_t       ge;
    rdy_t         re;
    reset     = rst;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    g = -1;
    if (rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0;
    end else begin
      for (int i = 0; i < N; i++) was_full[i] = m_full[i];
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) begin
        ge.edge_n = cyc + 1;
        ge.addr   = m_addr[g];
        ge.data   = m_data[g];
        ge.gid    = g;
        gq.push_back(ge);
        m_full[g] = 1'b0;
        m_ptr     = (g + 1) % N;
        if (m_addr[g] != 0) exp_bank[m_addr[g]] = m_data[g];
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && !was_full[i]) begin
          m_full[i] = 1'b1;
          m_addr[i] = a[i*AB +: AB];
          m_data[i] = d[i*W +: W];
        end
      end
    end
    re.edge_n = cyc + 1;
    for (int i = 0; i < N; i++) re.ready[i] = !m_full[i];
    rq.push_back(re);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
  endtask

  // Monitor: compares DUT outputs shortly after each active edge.
  rdy_t          mr;
  grant_t        mg;
  logic [NE-1:0] exp_en;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rq.size() > 0) begin
        mr = rq.pop_front();
        chk("req_ready", 128'(req_ready), 128'(mr.ready));
      end
      if (wr_valid) begin
        if (gq.size() == 0 || gq[0].edge_n != cyc) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write at cycle %0d: got grant_id=%0d addr=%0d expected none",
                   cyc, grant_id, wr_addr);
        end else begin
          mg = gq.pop_front();
          exp_en = '0;
          if (mg.addr != 0) exp_en[mg.addr] = 1'b1;
          chk("grant_id", 128'(grant_id), 128'(mg.gid));
          chk("wr_addr", 128'(wr_addr), 128'(mg.addr));
          chk("wr_data", 128'(wr_data), 128'(mg.data));
          chk("wr_enables", 128'(wr_enables), 128'(exp_en));
        end
      end else if (gq.size() > 0 && gq[0].edge_n == cyc) begin
        mg = gq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write at cycle %0d: got wr_valid=0 expected grant_id=%0d",
                 cyc, mg.gid);
      end else begin
        chk("wr_enables_idle", 128'(wr_enables), 128'(0));
      end
    end
  end

  logic [N*AB-1:0] a;
  logic [N*W-1:0]  d;
  logic [N-1:0]    v;

  initial begin
    // Reset then idle.
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    chk("rst_wr_valid", 128'(wr_valid), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", 128'(wr_data), 128'(0));
    chk("rst_grant_id", 128'(grant_id), 128'(0));
    chk("rst_wr_enables", 128'(wr_enables), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(4'hf));

    // Single write from requester 2.
    a = '0; d = '0;
    a[2*AB +: AB] = 5'd5;
    d[2*W +: W]   = 32'hDEADBEEF;
    step(1'b0, 4'b0100, a, d);
    idle(1);
    chk("single_grant_id", 128'(grant_id), 128'(2));
    chk("single_wr_valid", 128'(wr_valid), 128'(1));
    chk("single_enables", 128'(wr_enables), 128'(32'h0000_0020));
    idle(1);
    chk("single_r5", 128'(bank[5]), 128'(32'hDEADBEEF));
    idle(1);

    // Round-robin fairness with all requesters continuously valid.
    step(1'b1, '0, '0, '0);
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i*AB +: AB] = AB'(16 + i);
        d[i*W +: W]   = $urandom;
      end
      step(1'b0, 4'b1111, a, d);
      if (k >= 1) chk("rr_grant_seq", 128'(grant_id), 128'((k - 1) % N));
    end
    idle(6);

    // Register 0 suppression.
    a = '0; d = '0;
    d[1*W +: W] = 32'h1234;
    step(1'b0, 4'b0010, a, d);
    idle(1);
    chk("r0_wr_valid", 128'(wr_valid), 128'(1));
    chk("r0_grant_id", 128'(grant_id), 128'(1));
    chk("r0_enables", 128'(wr_enables), 128'(0));
    idle(1);
    chk("r0_bank", 128'(bank[0]), 128'(0));

    // Same-address ordering.
    step(1'b1, '0, '0, '0);
    a = '0; d = '0;
    a[0*AB +: AB] = 5'd7;  d[0*W +: W] = 32'hA;
    a[3*AB +: AB] = 5'd7;  d[3*W +: W] = 32'hB;
    step(1'b0, 4'b1001, a, d);
    idle(1);
    chk("same_first", 128'(grant_id), 128'(0));
    idle(1);
    chk("same_second", 128'(grant_id), 128'(3));
    idle(1);
    chk("same_r7", 128'(bank[7]), 128'(32'hB));

    // Reset while a write is presented and two buffers are pending.
    step(1'b1, '0, '0, '0);
    a = '0; d = '0;
    a[0*AB +: AB] = 5'd10; d[0*W +: W] = 32'h1111_0000;
    step(1'b0, 4'b0001, a, d);
    a[1*AB +: AB] = 5'd11; d[1*W +: W] = 32'h2222_0000;
    a[2*AB +: AB] = 5'd12; d[2*W +: W] = 32'h3333_0000;
    step(1'b0, 4'b0110, a, d);
    chk("mid_presented", 128'({wr_valid, grant_id}), 128'({1'b1, 2'd0}));
    step(1'b1, '0, '0, '0);
    idle(2);
    chk("mid_r10", 128'(bank[10]), 128'(32'h1111_0000));
    chk("mid_r11", 128'(bank[11]), 128'(0));
    chk("mid_r12", 128'(bank[12]), 128'(0));
    chk("mid_wr_valid", 128'(wr_valid), 128'(0));
    chk("mid_ready", 128'(req_ready), 128'(4'hf));

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      v = N'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i*AB +: AB] = AB'($urandom_range(0, 9));
        d[i*W +: W]   = $urandom;
      end
      step($urandom_range(0, 63) == 0, v, a, d);
    end
    idle(8);

    for (int i = 0; i < NE; i++) chk("final_bank", 128'(bank[i]), 128'(exp_bank[i]));
    chk("grants_drained", 128'(gq.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
